bus_cycle_controller: RTL
=========================

BUS_CYCLE_CONTROLLER -- requirements
Module: bus_cycle_controller

Interface
REQ-001 SHALL have port: clk_2  input  1  sole clock; every state change happens on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: halt  input  1  when high at the X3 check point, holds the machine in X3.
REQ-004 SHALL have port: io_write  input  1  the current instruction drives the accumulator onto the bus in X2.
REQ-005 SHALL have port: io_read  input  1  the current instruction captures the bus in X2.
REQ-006 SHALL have port: src_cmd  input  1  the current instruction drives a register pair in X2 (high nibble) and X3 (low nibble).
REQ-007 SHALL have port: cycle_state  output  3  current state; A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
REQ-008 SHALL have port: phase  output  1  sub-phase within the state; 0 = load/capture, 1 = drive/hold.
REQ-009 SHALL have port: sync  output  1  high during X3.
REQ-010 SHALL have port: data_bus_buffer_enable  output  1  active-low enable to the data bus buffer.
REQ-011 SHALL have port: data_bus_buffer_path  output  2  buffer path code: 00 = load D0_D3, 01 = drive bus, 10 = idle, 11 = capture bus.
REQ-012 SHALL have port: src_sel  output  3  D0_D3 source select: 0 = PC[3:0], 1 = PC[7:4], 2 = PC[11:8], 3 = ACC, 4 = RP high, 5 = RP low.
REQ-013 SHALL have port: opr_strobe, opa_strobe, io_rd_strobe  output  1 each  single-cycle latch pulses.

Function
REQ-014 SHALL step (state, phase) as follows: phase 0 -> 1 within a state; phase 1 -> phase 0 of the next state; X3 wraps to A1. This gives 16 clk_2 cycles per machine cycle.
REQ-015 SHALL derive all outputs as a Moore decode of the state, the phase and the latched command register.
REQ-016 SHALL, in A1, A2 and A3, drive enable=0 and src_sel=0, 1 and 2 respectively; path=00 in phase 0 and path=01 in phase 1.
REQ-017 SHALL, in M1 and M2, drive enable=0; path=11 in phase 0 and path=10 in phase 1.
REQ-018 SHALL pulse opr_strobe in M1 phase 1 and opa_strobe in M2 phase 1.
REQ-019 SHALL, in X1, drive enable=1 and path=10.
REQ-020 SHALL sample io_write, io_read and src_cmd on the edge leaving M2 phase 1 into a one-hot command register, with priority src_cmd > io_write > io_read; other bits are ignored.
REQ-021 SHALL clear the command register on entry to A1.
REQ-022 SHALL hold the command register constant from X1 through X3.
REQ-023 SHALL, in X2 with WRITE latched, drive enable=0 and src_sel=3; path=00 in phase 0 and 01 in phase 1.
REQ-024 SHALL, in X2 with READ latched, drive enable=0; path=11 in phase 0 and 10 in phase 1, with io_rd_strobe high in phase 1.
REQ-025 SHALL, in X2 with SRC latched, drive enable=0 and src_sel=4; path 00 then 01.
REQ-026 SHALL, in X3 with SRC latched, drive enable=0 and src_sel=5; path 00 then 01.
REQ-027 SHALL, in X2 and X3 with no command latched, drive enable=1 and path=10.
REQ-028 SHALL keep sync=1 for both phases of X3 and sync=0 otherwise.
REQ-029 SHALL sample halt on the edge leaving X3 phase 1: if high, go to X3 phase 0 instead of A1, and clear the command register.
REQ-030 SHALL hold sync=1, enable=1 and path=10 while halted.
REQ-031 SHALL resume with A1 phase 0 on the first X3-phase-1 edge that sees halt low.
REQ-032 SHALL ignore halt in every other state and phase.
REQ-033 SHALL drive src_sel=0 in every state/phase where it is not otherwise specified.
REQ-034 SHALL drive all strobes low in every state/phase where they are not otherwise specified.

Reset
REQ-035 SHALL, while rst_n=0, force state=A1, phase=0 and command register=none, independent of clk_2.
REQ-036 SHALL produce these output reset values: cycle_state=0, phase=0, sync=0, enable=0, path=00, src_sel=0, all strobes 0.
REQ-037 SHALL, if rst_n is asserted mid-cycle (including while halted or during an X2 drive), abandon that cycle immediately; the first rising edge after release advances to A1 phase 1.

Verification
REQ-038 SHALL cover: release reset, all cmd inputs 0, halt 0 -> cycle_state sequence 0,0,1,1,...,7,7 repeating with period 16; sync high exactly 2 of 16 cycles; enable=1 in X1-X3.
REQ-039 SHALL cover: io_write=1 held through M2 phase 1 -> X2 gives src_sel=3 with path 00 then 01; X3 is idle; cycle n+1 with io_write=0 has no X2 drive.
REQ-040 SHALL cover: io_read=1 and io_write=1 together at M2 -> WRITE wins; io_read alone -> path 11 then 10 in X2 and one io_rd_strobe pulse.
REQ-041 SHALL cover: src_cmd=1 -> X2 src_sel=4 and X3 src_sel=5, both with path 00 then 01.
REQ-042 SHALL cover: halt=1 for 3 X3 checks -> X3 repeats 3 extra times (6 cycles, sync=1 throughout); after release A1 follows; opr_strobe count is unchanged by the halt.
REQ-043 SHALL cover: rst_n pulsed low during X2 of a WRITE cycle -> outputs take reset values asynchronously; after release no X2 drive occurs until a new command is sampled.

Source files
------------

// File: rtl/bus_cycle_controller.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller
// Sequences a 16-cycle bus machine cycle: eight states (A1..A3, M1, M2, X1..X3)
// with two sub-phases each. It drives the data bus buffer controls, the D0_D3
// source select and the opcode/operand/IO-read latch strobes. A command sampled
// at the end of M2 selects what happens in X2/X3. Halt stalls the machine in X3.
//
// Ports
//   clk_2                  : clock; all state changes on its rising edge
//   rst_n                  : asynchronous active-low reset
//   halt                   : sampled leaving X3 phase 1; repeats X3 while high
//   io_write / io_read     : instruction writes / reads the bus in X2
//   src_cmd                : instruction drives a register pair in X2/X3
//   cycle_state[2:0]       : current state (A1=0 .. X3=7)
//   phase                  : 0 = load/capture, 1 = drive/hold
//   sync                   : high during X3
//   data_bus_buffer_enable : active-low buffer enable
//   data_bus_buffer_path   : 00 load, 01 drive, 10 idle, 11 capture
//   src_sel[2:0]           : D0_D3 source select
//   opr_strobe, opa_strobe, io_rd_strobe : single-cycle latch pulses
// -----------------------------------------------------------------------------
module bus_cycle_controller (
    input  logic       clk_2,
    input  logic       rst_n,
    input  logic       halt,
    input  logic       io_write,
    input  logic       io_read,
    input  logic       src_cmd,
    output logic [2:0] cycle_state,
    output logic       phase,
    output logic       sync,
    output logic       data_bus_buffer_enable,
    output logic [1:0] data_bus_buffer_path,
    output logic [2:0] src_sel,
    output logic       opr_strobe,
    output logic       opa_strobe,
    output logic       io_rd_strobe
);

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CMD_W   = 3;
    localparam int unsigned PATH_W  = 2;
    localparam int unsigned SEL_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_A1 = 3'd0,
        ST_A2 = 3'd1,
        ST_A3 = 3'd2,
        ST_M1 = 3'd3,
        ST_M2 = 3'd4,
        ST_X1 = 3'd5,
        ST_X2 = 3'd6,
        ST_X3 = 3'd7
    } state_t;

    // One-hot command register encodings
    localparam logic [CMD_W-1:0] CMD_NONE  = 3'b000;
    localparam logic [CMD_W-1:0] CMD_READ  = 3'b001;
    localparam logic [CMD_W-1:0] CMD_WRITE = 3'b010;
    localparam logic [CMD_W-1:0] CMD_SRC   = 3'b100;

    localparam logic [PATH_W-1:0] PATH_LOAD    = 2'b00;
    localparam logic [PATH_W-1:0] PATH_DRIVE   = 2'b01;
    localparam logic [PATH_W-1:0] PATH_IDLE    = 2'b10;
    localparam logic [PATH_W-1:0] PATH_CAPTURE = 2'b11;

    localparam logic [SEL_W-1:0] SEL_PC0 = 3'd0;
    localparam logic [SEL_W-1:0] SEL_PC1 = 3'd1;
    localparam logic [SEL_W-1:0] SEL_PC2 = 3'd2;
    localparam logic [SEL_W-1:0] SEL_ACC = 3'd3;
    localparam logic [SEL_W-1:0] SEL_RPH = 3'd4;
    localparam logic [SEL_W-1:0] SEL_RPL = 3'd5;

    state_t             state_q, state_d;
    logic               phase_q, phase_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;

    logic               sync_d;
    logic               enable_d;
    logic [PATH_W-1:0]  path_d;
    logic [SEL_W-1:0]   sel_d;
    logic               opr_d;
    logic               opa_d;
    logic               rd_d;

    // Path codes for "load then drive" and "capture then idle" sequences
    logic [PATH_W-1:0]  load_path;
    logic [PATH_W-1:0]  capture_path;

    assign load_path    = phase_d ? PATH_DRIVE : PATH_LOAD;
    assign capture_path = phase_d ? PATH_IDLE  : PATH_CAPTURE;

    assign cycle_state = state_q;
    assign phase       = phase_q;

    // Next (state, phase, command): phase toggles, state advances after phase 1
    always_comb begin
        state_d = state_q;
        phase_d = ~phase_q;
        cmd_d   = cmd_q;
        if (phase_q) begin
            case (state_q)
                ST_M2: begin
                    state_d = ST_X1;
                    if (src_cmd)       cmd_d = CMD_SRC;
                    else if (io_write) cmd_d = CMD_WRITE;
                    else if (io_read)  cmd_d = CMD_READ;
                    else               cmd_d = CMD_NONE;
                end
                ST_X3: begin
                    // Halt re-enters X3 with no command; otherwise wrap to A1
                    state_d = halt ? ST_X3 : ST_A1;
                    cmd_d   = CMD_NONE;
                end
                default: state_d = state_t'(STATE_W'(state_q + 3'd1));
            endcase
        end
    end

    // Moore decode of the next (state, phase, command) so outputs are registered
    always_comb begin
        sync_d   = 1'b0;
        enable_d = 1'b1;
        path_d   = PATH_IDLE;
        sel_d    = SEL_PC0;
        opr_d    = 1'b0;
        opa_d    = 1'b0;
        rd_d     = 1'b0;
        case (state_d)
            ST_A1: begin
                enable_d = 1'b0;
                path_d   = load_path;
                sel_d    = SEL_PC0;
            end
            ST_A2: begin
                enable_d = 1'b0;
                path_d   = load_path;
                sel_d    = SEL_PC1;
            end
            ST_A3: begin
                enable_d = 1'b0;
                path_d   = load_path;
                sel_d    = SEL_PC2;
            end
            ST_M1: begin
                enable_d = 1'b0;
                path_d   = capture_path;
                opr_d    = phase_d;
            end
            ST_M2: begin
                enable_d = 1'b0;
                path_d   = capture_path;
                opa_d    = phase_d;
            end
            ST_X1: begin
                enable_d = 1'b1;
                path_d   = PATH_IDLE;
            end
            ST_X2: begin
                if (cmd_d == CMD_WRITE) begin
                    enable_d = 1'b0;
                    path_d   = load_path;
                    sel_d    = SEL_ACC;
                end else if (cmd_d == CMD_READ) begin
                    enable_d = 1'b0;
                    path_d   = capture_path;
                    rd_d     = phase_d;
                end else if (cmd_d == CMD_SRC) begin
                    enable_d = 1'b0;
                    path_d   = load_path;
                    sel_d    = SEL_RPH;
                end
            end
            ST_X3: begin
                sync_d = 1'b1;
                if (cmd_d == CMD_SRC) begin
                    enable_d = 1'b0;
                    path_d   = load_path;
                    sel_d    = SEL_RPL;
                end
            end
        endcase
    end

    // State, command and output registers
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q                <= ST_A1;
            phase_q                <= 1'b0;
            cmd_q                  <= CMD_NONE;
            sync                   <= 1'b0;
            data_bus_buffer_enable <= 1'b0;
            data_bus_buffer_path   <= PATH_LOAD;
            src_sel                <= SEL_PC0;
            opr_strobe             <= 1'b0;
            opa_strobe             <= 1'b0;
            io_rd_strobe           <= 1'b0;
        end else begin
            state_q                <= state_d;
            phase_q                <= phase_d;
            cmd_q                  <= cmd_d;
            sync                   <= sync_d;
            data_bus_buffer_enable <= enable_d;
            data_bus_buffer_path   <= path_d;
            src_sel                <= sel_d;
            opr_strobe             <= opr_d;
            opa_strobe             <= opa_d;
            io_rd_strobe           <= rd_d;
        end
    end

endmodule
